// File: rtl/phase_accumulator.sv
// Audio-rate phase accumulator with a one-deep frequency input buffer and
// optional portamento that slews the increment toward a new target.
module phase_accumulator #(
    parameter int WIDTH       = 19,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic [WIDTH-1:0] freq_word,
    input  logic             freq_valid,
    output logic             freq_ready,
    input  logic             glide_en,
    input  logic             gate,
    output logic [WIDTH-1:0] phase,
    output logic             wrap,
    output logic             phase_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GLIDE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] inc_r;
    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] pending_s;
    logic             pending_full_r;
    logic             pending_full_s;
    logic [WIDTH-1:0] phase_s;
    logic             wrap_s;
    logic             phase_valid_s;
    logic             busy_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] stepped_s;
    logic             accept_s;

    // One glide step from cur toward tgt; lands exactly on tgt once within one step.
    function automatic logic [WIDTH-1:0] glide_step(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] diff;
        logic [WIDTH:0] mag;
        logic [WIDTH:0] step;
        diff = {1'b0, tgt} - {1'b0, cur};
        if (diff[WIDTH]) begin
            mag = -diff;
        end else begin
            mag = diff;
        end
        step = mag >> GLIDE_SHIFT;
        if (step == '0) begin
            step = {{WIDTH{1'b0}}, 1'b1};
        end else begin
            step = step;
        end
        if (mag <= step) begin
            glide_step = tgt;
        end else if (diff[WIDTH]) begin
            glide_step = cur - step[WIDTH-1:0];
        end else begin
            glide_step = cur + step[WIDTH-1:0];
        end
    endfunction

    assign freq_ready = !pending_full_r && !reset;
    assign accept_s   = freq_valid && freq_ready;
    assign sum_s      = {1'b0, phase} + {1'b0, inc_r};
    assign stepped_s  = glide_step(inc_r, target_r);

    // Next-state, buffer and tick-action logic; everything right of '=' is pre-tick.
    always_comb begin
        state_s        = state_r;
        inc_s          = inc_r;
        target_s       = target_r;
        pending_s      = pending_r;
        pending_full_s = pending_full_r;
        phase_s        = phase;
        wrap_s         = 1'b0;
        phase_valid_s  = 1'b0;

        if (accept_s) begin
            pending_s      = freq_word;
            pending_full_s = 1'b1;
        end else if (sample_tick && pending_full_r) begin
            pending_full_s = 1'b0;
        end else begin
            pending_full_s = pending_full_r;
        end

        if (sample_tick) begin
            phase_valid_s = 1'b1;
            if (pending_full_r) begin
                target_s = pending_r;
            end else begin
                target_s = target_r;
            end
            case (state_r)
                IDLE: begin
                    // No glide from silence: a new word takes effect immediately.
                    phase_s = '0;
                    if (pending_full_r) begin
                        inc_s = pending_r;
                    end else begin
                        inc_s = inc_r;
                    end
                    state_s = gate ? RUN : IDLE;
                end
                RUN, GLIDE: begin
                    if (!gate) begin
                        phase_s = '0;
                        state_s = IDLE;
                    end else begin
                        {wrap_s, phase_s} = sum_s;
                        if (pending_full_r && !glide_en) begin
                            inc_s   = pending_r;
                            state_s = RUN;
                        end else if (pending_full_r) begin
                            // An in-flight glide still steps toward the old target this tick.
                            inc_s   = (state_r == GLIDE) ? stepped_s : inc_r;
                            state_s = (pending_r != inc_s) ? GLIDE : RUN;
                        end else if (state_r == GLIDE) begin
                            inc_s   = glide_en ? stepped_s : target_r;
                            state_s = (inc_s == target_r) ? RUN : GLIDE;
                        end else begin
                            state_s = RUN;
                        end
                    end
                end
                default: begin
                    phase_s = '0;
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s == GLIDE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            inc_r          <= '0;
            target_r       <= '0;
            pending_r      <= '0;
            pending_full_r <= 1'b0;
            phase          <= '0;
            wrap           <= 1'b0;
            phase_valid    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_r        <= state_s;
            inc_r          <= inc_s;
            target_r       <= target_s;
            pending_r      <= pending_s;
            pending_full_r <= pending_full_s;
            phase          <= phase_s;
            wrap           <= wrap_s;
            phase_valid    <= phase_valid_s;
            busy           <= busy_s;
        end
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: directed scenarios plus a
// randomized run against an integer reference model.
module tb_phase_accumulator;

    localparam int W       = 19;
    localparam int GS      = 4;
    localparam int MOD     = 1 << W;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_GLIDE = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_tick = 1'b0;
    logic [W-1:0] freq_word = '0;
    logic         freq_valid = 1'b0;
    logic         freq_ready;
    logic         glide_en = 1'b0;
    logic         gate = 1'b0;
    logic [W-1:0] phase;
    logic         wrap;
    logic         phase_valid;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    int m_phase, m_inc, m_target, m_pend, m_mode;
    bit m_full, e_valid, e_wrap;

    phase_accumulator #(.WIDTH(W), .GLIDE_SHIFT(GS)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .freq_word(freq_word), .freq_valid(freq_valid), .freq_ready(freq_ready),
        .glide_en(glide_en), .gate(gate), .phase(phase), .wrap(wrap),
        .phase_valid(phase_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mglide(int cur, int tgt);
        int d, m, s;
        d = tgt - cur;
        m = (d < 0) ? -d : d;
        s = m >> GS;
        if (s < 1) s = 1;
        if (m <= s) return tgt;
        return (d < 0) ? cur - s : cur + s;
    endfunction

    task automatic model_tick();
        int old_t, s;
        bit xfer;
        xfer   = m_full;
        old_t  = m_target;
        e_wrap = 1'b0;
        if (xfer) begin
            m_target = m_pend;
            m_full   = 1'b0;
        end
        if (m_mode == M_IDLE) begin
            m_phase = 0;
            if (xfer) m_inc = m_pend;
            if (gate) m_mode = M_RUN;
        end else if (!gate) begin
            m_phase = 0;
            m_mode  = M_IDLE;
        end else begin
            s       = m_phase + m_inc;
            e_wrap  = (s >= MOD);
            m_phase = s % MOD;
            if (xfer && !glide_en) begin
                m_inc  = m_pend;
                m_mode = M_RUN;
            end else if (xfer) begin
                if (m_mode == M_GLIDE) m_inc = mglide(m_inc, old_t);
                m_mode = (m_inc != m_pend) ? M_GLIDE : M_RUN;
            end else if (m_mode == M_GLIDE) begin
                m_inc = glide_en ? mglide(m_inc, old_t) : old_t;
                if (m_inc == old_t) m_mode = M_RUN;
            end
        end
    endtask

    // One clock cycle of stimulus; called and returns at 1 ns after a rising edge.
    task automatic cycle(input bit tk, input bit snd, input logic [W-1:0] w);
        bit rdy;
        sample_tick = tk;
        freq_valid  = snd;
        freq_word   = w;
        rdy         = freq_ready;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        freq_valid  = 1'b0;
        e_valid     = tk;
        e_wrap      = 1'b0;
        if (tk) model_tick();
        if (snd && rdy) begin
            m_full = 1'b1;
            m_pend = int'(w);
        end
    endtask

    task automatic tick();
        cycle(1'b1, 1'b0, '0);
    endtask

    task automatic gap();
        cycle(1'b0, 1'b0, '0);
    endtask

    task automatic send(input logic [W-1:0] w);
        cycle(1'b0, 1'b1, w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_tick = 1'b0;
        freq_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({phase, wrap, phase_valid, busy, freq_ready} !== {{W{1'b0}}, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got phase=%h wrap=%b valid=%b busy=%b ready=%b, want all 0",
                     phase, wrap, phase_valid, busy, freq_ready);
        end
        @(posedge clk);
        #1;
        m_phase = 0; m_inc = 0; m_target = 0; m_pend = 0; m_mode = M_IDLE;
        m_full = 1'b0; e_valid = 1'b0; e_wrap = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++;
        if (freq_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", freq_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        gate = 1'b0;
        glide_en = 1'b0;
        do_reset();
        tests_run++;
        if (dut.inc_r !== '0 || dut.target_r !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: got inc=%h target=%h want 0", dut.inc_r, dut.target_r);
        end
    endtask

    task automatic test_ramp();
        int exp;
        do_reset();
        gate = 1'b1;
        send(19'h01000);
        tick();
        tests_run++;
        if (phase_valid !== 1'b1 || phase !== 19'h00000 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_sync: got valid=%b phase=%h wrap=%b want 1/00000/0", phase_valid, phase, wrap);
        end
        gap();
        tests_run++;
        if (phase_valid !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_pulse_width: got valid=%b wrap=%b want 0/0", phase_valid, wrap);
        end
        for (int k = 1; k <= 128; k++) begin
            tick();
            exp = (k * 32'h1000) % MOD;
            tests_run++;
            if (phase !== exp[W-1:0] || wrap !== (k == 128) || phase_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL ramp_add_%0d: got phase=%h wrap=%b valid=%b want phase=%h wrap=%b valid=1",
                         k, phase, wrap, phase_valid, exp[W-1:0], (k == 128));
            end
            gap();
        end
    endtask

    task automatic test_odd_wrap();
        logic [W-1:0] exp_p [3];
        logic         exp_w [3];
        exp_p[0] = 19'h60000; exp_w[0] = 1'b0;
        exp_p[1] = 19'h40000; exp_w[1] = 1'b1;
        exp_p[2] = 19'h20000; exp_w[2] = 1'b1;
        do_reset();
        gate = 1'b1;
        send(19'h60000);
        tick();
        gap();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (phase !== exp_p[i] || wrap !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL odd_wrap_%0d: got phase=%h wrap=%b want phase=%h wrap=%b",
                         i, phase, wrap, exp_p[i], exp_w[i]);
            end
            gap();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gate = 1'b0;
        cycle(1'b0, 1'b1, 19'h00100);
        tests_run++;
        if (freq_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ready_drop: got %b want 0", freq_ready);
        end
        cycle(1'b0, 1'b1, 19'h00200);
        tests_run++;
        if (freq_ready !== 1'b0 || dut.target_r !== 19'h00000) begin
            tests_failed++;
            $display("FAIL bp_hold: got ready=%b target=%h want 0/00000", freq_ready, dut.target_r);
        end
        cycle(1'b1, 1'b1, 19'h00200);
        tests_run++;
        if (dut.target_r !== 19'h00100 || freq_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_transfer: got target=%h ready=%b want 00100/1", dut.target_r, freq_ready);
        end
        cycle(1'b0, 1'b1, 19'h00200);
        tests_run++;
        if (freq_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_second_accept: got ready=%b want 0", freq_ready);
        end
        tick();
        tests_run++;
        if (dut.target_r !== 19'h00200 || dut.inc_r !== 19'h00200 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle_direct: got target=%h inc=%h busy=%b want 00200/00200/0",
                     dut.target_r, dut.inc_r, busy);
        end
        gap();
    endtask

    task automatic test_glide();
        logic [W-1:0] prev;
        bit done;
        do_reset();
        gate = 1'b1;
        glide_en = 1'b0;
        send(19'h00100);
        tick();
        gap();
        glide_en = 1'b1;
        send(19'h00200);
        tick();
        tests_run++;
        if (busy !== 1'b1 || dut.inc_r !== 19'h00100) begin
            tests_failed++;
            $display("FAIL glide_start: got busy=%b inc=%h want 1/00100", busy, dut.inc_r);
        end
        gap();
        prev = 19'h00100;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            tests_run++;
            if (dut.inc_r !== m_inc[W-1:0] || dut.inc_r <= prev ||
                (n == 0 && dut.inc_r !== 19'h00110) || (n == 1 && dut.inc_r !== 19'h0011F)) begin
                tests_failed++;
                $display("FAIL glide_step_%0d: got inc=%h prev=%h want inc=%h", n, dut.inc_r, prev, m_inc[W-1:0]);
            end
            prev = dut.inc_r;
            done = !busy;
            gap();
        end
        tests_run++;
        if (!done || dut.inc_r !== 19'h00200 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glide_end: got done=%b inc=%h busy=%b want 1/00200/0", done, dut.inc_r, busy);
        end
        glide_en = 1'b0;
        send(19'h00100);
        tick();
        gap();
        send(19'h00200);
        tick();
        tests_run++;
        if (dut.inc_r !== 19'h00200 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glide_off_jump: got inc=%h busy=%b want 00200/0", dut.inc_r, busy);
        end
        gap();
        glide_en = 1'b1;
        send(19'h01000);
        tick();
        gap();
        tick();
        gap();
        glide_en = 1'b0;
        tick();
        tests_run++;
        if (dut.inc_r !== 19'h01000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glide_drop: got inc=%h busy=%b want 01000/0", dut.inc_r, busy);
        end
        gap();
    endtask

    task automatic test_gate();
        do_reset();
        gate = 1'b1;
        glide_en = 1'b0;
        send(19'h12345);
        tick();
        gap();
        tick();
        tests_run++;
        if (phase !== 19'h12345) begin
            tests_failed++;
            $display("FAIL gate_running: got phase=%h want 12345", phase);
        end
        gap();
        gate = 1'b0;
        tick();
        tests_run++;
        if (phase !== 19'h00000 || wrap !== 1'b0 || phase_valid !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gate_off: got phase=%h wrap=%b valid=%b busy=%b want 00000/0/1/0",
                     phase, wrap, phase_valid, busy);
        end
        gap();
        gate = 1'b1;
        tick();
        tests_run++;
        if (phase !== 19'h00000 || phase_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL gate_resync: got phase=%h valid=%b want 00000/1", phase, phase_valid);
        end
        gap();
        tick();
        tests_run++;
        if (phase !== 19'h12345) begin
            tests_failed++;
            $display("FAIL gate_resume: got phase=%h want 12345", phase);
        end
        gap();
    endtask

    task automatic test_reset_mid_glide();
        do_reset();
        gate = 1'b1;
        glide_en = 1'b0;
        send(19'h00100);
        tick();
        gap();
        glide_en = 1'b1;
        send(19'h40000);
        tick();
        gap();
        tick();
        send(19'h00500);
        tests_run++;
        if (busy !== 1'b1 || freq_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_glide_setup: got busy=%b ready=%b want 1/0", busy, freq_ready);
        end
        do_reset();
        tests_run++;
        if (dut.inc_r !== '0 || dut.target_r !== '0) begin
            tests_failed++;
            $display("FAIL mid_glide_cleared: got inc=%h target=%h want 0/0", dut.inc_r, dut.target_r);
        end
        tick();
        tests_run++;
        if (dut.target_r !== '0 || phase !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_glide_pending_gone: got target=%h phase=%h busy=%b want 0/0/0",
                     dut.target_r, phase, busy);
        end
        gap();
    endtask

    task automatic test_random();
        bit prev_tick, tk, snd;
        logic [W-1:0] w;
        int lo;
        glide_en = 1'b0;
        gate = 1'b0;
        do_reset();
        prev_tick = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) gate = ~gate;
            if ($urandom_range(0, 7) == 0) glide_en = ~glide_en;
            tk  = !prev_tick && ($urandom_range(0, 2) != 0);
            snd = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) begin
                w = W'($urandom);
            end else begin
                lo = m_inc + int'($urandom_range(0, 64)) - 32;
                if (lo < 0) lo = 0;
                w = lo[W-1:0];
            end
            cycle(tk, snd, w);
            prev_tick = tk;
            tests_run++;
            if (phase !== m_phase[W-1:0] || wrap !== e_wrap || phase_valid !== e_valid ||
                busy !== (m_mode == M_GLIDE) || freq_ready !== !m_full || dut.inc_r !== m_inc[W-1:0]) begin
                tests_failed++;
                $display("FAIL random_%0d: got phase=%h wrap=%b valid=%b busy=%b ready=%b inc=%h want phase=%h wrap=%b valid=%b busy=%b ready=%b inc=%h",
                         i, phase, wrap, phase_valid, busy, freq_ready, dut.inc_r,
                         m_phase[W-1:0], e_wrap, e_valid, (m_mode == M_GLIDE), !m_full, m_inc[W-1:0]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_odd_wrap();
        test_backpressure();
        test_glide();
        test_gate();
        test_reset_mid_glide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
